// File: rtl/zb_frame_pkg.sv
// Shared types and constants for the zb_frame_tx transmit frame builder.
// Contents: FSM state enum, default SFD byte, CRC-16 polynomial/init, field widths.
package zb_frame_pkg;

    localparam int unsigned PHR_W = 8;
    localparam int unsigned LEN_W = 7;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned CRC_W = 16;

    localparam logic [7:0]       SFD_DEFAULT = 8'hA7;
    localparam logic [CRC_W-1:0] CRC_POLY    = 16'h8408;
    localparam logic [CRC_W-1:0] CRC_INIT    = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PHR,
        ST_PAYLOAD,
        ST_FCS,
        ST_DONE
    } zb_state_e;

endpackage

// File: rtl/zb_crc16_nibble.sv
// One nibble step of the reflected CRC-16 (poly 0x8408), bits consumed LSB first.
// Ports: crc_in (current CRC), nibble (data), crc_out (updated CRC). Purely combinational.
module zb_crc16_nibble
    import zb_frame_pkg::*;
(
    input  logic [CRC_W-1:0] crc_in,
    input  logic [3:0]       nibble,
    output logic [CRC_W-1:0] crc_out
);

    // Four serial shift steps unrolled.
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 4; i++) begin
            if (crc_out[0] ^ nibble[i]) begin
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/zb_frame_tx.sv
// Transmit frame builder: wraps a host nibble stream in preamble/SFD/PHR[/FCS]
// and writes it one nibble per cycle into the modulator input FIFO.
// Optional FCS generation is enabled by defining ZB_FRAME_TX_FCS_EN.
// Ports: inClock/inReset (async active-low); inStart/inLength frame request;
// inData/inValid/outReady host stream; inFull/outWriteEnable/outData FIFO side;
// outBusy, outDone (end-of-frame pulse), outError (rejected-request pulse).
module zb_frame_tx
    import zb_frame_pkg::*;
#(
    parameter int unsigned PREAMBLE_NIBBLES = 8,
    parameter logic [7:0]  SFD_BYTE         = SFD_DEFAULT,
    parameter int unsigned MAX_LEN          = 127
) (
    input  logic             inClock,
    input  logic             inReset,
    input  logic             inStart,
    input  logic [LEN_W-1:0] inLength,
    input  logic [3:0]       inData,
    input  logic             inValid,
    output logic             outReady,
    input  logic             inFull,
    output logic             outWriteEnable,
    output logic [3:0]       outData,
    output logic             outBusy,
    output logic             outDone,
    output logic             outError
);

`ifdef ZB_FRAME_TX_FCS_EN
    localparam int unsigned LEN_LIMIT = MAX_LEN - 2;
    localparam int unsigned PHR_ADD   = 2;
`else
    localparam int unsigned LEN_LIMIT = MAX_LEN;
    localparam int unsigned PHR_ADD   = 0;
`endif

    zb_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_error;

    logic             w_we;
    logic             w_ready;
    logic [3:0]       w_data;
    logic [PHR_W-1:0] w_phr;
    logic             w_len_ok;
    logic             w_payload_last;

    assign w_phr          = PHR_W'({1'b0, r_len}) + PHR_W'(PHR_ADD);
    assign w_len_ok       = (inLength != '0) && ({1'b0, inLength} <= PHR_W'(LEN_LIMIT));
    assign w_payload_last = (r_cnt == ({r_len, 1'b0} - CNT_W'(1)));

`ifdef ZB_FRAME_TX_FCS_EN
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_crc_next;

    zb_crc16_nibble u_crc (
        .crc_in  (r_crc),
        .nibble  (inData),
        .crc_out (w_crc_next)
    );
`endif

    // FIFO-side strobe and nibble mux; payload is a straight passthrough.
    always_comb begin
        w_we    = 1'b0;
        w_ready = 1'b0;
        w_data  = 4'h0;
        case (r_state)
            ST_PREAMBLE: begin
                w_we = !inFull;
            end
            ST_SFD: begin
                w_we   = !inFull;
                w_data = r_cnt[0] ? SFD_BYTE[7:4] : SFD_BYTE[3:0];
            end
            ST_PHR: begin
                w_we   = !inFull;
                w_data = r_cnt[0] ? w_phr[7:4] : w_phr[3:0];
            end
            ST_PAYLOAD: begin
                w_ready = !inFull;
                w_we    = inValid && !inFull;
                w_data  = inData;
            end
`ifdef ZB_FRAME_TX_FCS_EN
            ST_FCS: begin
                w_we = !inFull;
                case (r_cnt[1:0])
                    2'd0:    w_data = r_crc[3:0];
                    2'd1:    w_data = r_crc[7:4];
                    2'd2:    w_data = r_crc[11:8];
                    default: w_data = r_crc[15:12];
                endcase
            end
`endif
            default: begin
            end
        endcase
    end

    // Frame sequencer; counters only advance on an actual write, so a stall holds everything.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_error <= 1'b0;
`ifdef ZB_FRAME_TX_FCS_EN
            r_crc   <= CRC_INIT;
`endif
        end else begin
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (inStart) begin
                        if (w_len_ok) begin
                            r_len   <= inLength;
                            r_cnt   <= '0;
                            r_state <= ST_PREAMBLE;
`ifdef ZB_FRAME_TX_FCS_EN
                            r_crc   <= CRC_INIT;
`endif
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (w_we) begin
                        if (r_cnt == CNT_W'(PREAMBLE_NIBBLES - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_SFD;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_SFD: begin
                    if (w_we) begin
                        if (r_cnt[0]) begin
                            r_cnt   <= '0;
                            r_state <= ST_PHR;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PHR: begin
                    if (w_we) begin
                        if (r_cnt[0]) begin
                            r_cnt   <= '0;
                            r_state <= ST_PAYLOAD;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_we) begin
`ifdef ZB_FRAME_TX_FCS_EN
                        r_crc <= w_crc_next;
`endif
                        if (w_payload_last) begin
                            r_cnt <= '0;
`ifdef ZB_FRAME_TX_FCS_EN
                            r_state <= ST_FCS;
`else
                            r_state <= ST_DONE;
`endif
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef ZB_FRAME_TX_FCS_EN
                ST_FCS: begin
                    if (w_we) begin
                        if (r_cnt[1:0] == 2'd3) begin
                            r_cnt   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign outWriteEnable = w_we;
    assign outData        = w_data;
    assign outReady       = w_ready;
    assign outBusy        = (r_state != ST_IDLE);
    assign outDone        = (r_state == ST_DONE);
    assign outError       = r_error;

endmodule

// File: tb/tb_zb_frame_tx.sv
// Scoreboard bench for zb_frame_tx: stimulus pushes expected FIFO nibbles into a
// queue; a negedge monitor pops and compares on every outWriteEnable.
module tb_zb_frame_tx;

    logic       inClock;
    logic       inReset;
    logic       inStart;
    logic [6:0] inLength;
    logic [3:0] inData;
    logic       inValid;
    logic       outReady;
    logic       inFull;
    logic       outWriteEnable;
    logic [3:0] outData;
    logic       outBusy;
    logic       outDone;
    logic       outError;

    zb_frame_tx dut (
        .inClock        (inClock),
        .inReset        (inReset),
        .inStart        (inStart),
        .inLength       (inLength),
        .inData         (inData),
        .inValid        (inValid),
        .outReady       (outReady),
        .inFull         (inFull),
        .outWriteEnable (outWriteEnable),
        .outData        (outData),
        .outBusy        (outBusy),
        .outDone        (outDone),
        .outError       (outError)
    );

    initial inClock = 1'b0;
    always #5 inClock = ~inClock;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int err_cnt  = 0;
    int cyc      = 0;
    int first_wr = -1;
    int last_wr  = -1;
    bit host_pause = 1'b0;

    logic [3:0] exp_q[$];
    logic [3:0] host_q[$];
    logic [7:0] pay_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event, expected normal completion", name);
    endtask

`ifdef ZB_FRAME_TX_FCS_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [3:0] n);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            if (r[0] ^ n[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    // Monitor: every FIFO write is checked against the scoreboard.
    always @(negedge inClock) begin
        cyc++;
        if (!inReset) begin
            if (outWriteEnable) fail_now("write_during_reset");
        end else begin
            if (outWriteEnable) begin
                check("no_write_when_full", 32'(inFull), 32'd0);
                if (exp_q.size() == 0) fail_now("unexpected_write");
                else check("wr_nibble", 32'(outData), 32'(exp_q.pop_front()));
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (outDone) check("done_after_last_write", 32'(last_wr), 32'(cyc - 1));
            if (outError) err_cnt++;
        end
    end

    // Host driver: presents the next payload nibble, pops it on a sampled handshake.
    initial begin
        bit take;
        inValid = 1'b0;
        inData  = 4'h0;
        forever begin
            @(negedge inClock);
            take = inValid && outReady && inReset;
            @(posedge inClock);
            #2;
            if (take && host_q.size() > 0) void'(host_q.pop_front());
            inValid = (host_q.size() > 0) && !host_pause;
            inData  = inValid ? host_q[0] : 4'h0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge inClock);
        #1;
    endtask

    // Build expected frame from pay_q; fcs < 0 means use the reference CRC.
    task automatic push_frame(input int fcs, output int nw);
        logic [7:0]  phr;
        logic [15:0] crc;
        crc = 16'h0000;
        first_wr = -1;
        nw = 0;
        for (int i = 0; i < 8; i++) begin exp_q.push_back(4'h0); nw++; end
        exp_q.push_back(4'h7);
        exp_q.push_back(4'hA);
        phr = 8'(pay_q.size());
`ifdef ZB_FRAME_TX_FCS_EN
        phr = phr + 8'd2;
`endif
        exp_q.push_back(phr[3:0]);
        exp_q.push_back(phr[7:4]);
        nw += 4;
        foreach (pay_q[i]) begin
            logic [7:0] b;
            b = pay_q[i];
            exp_q.push_back(b[3:0]);
            exp_q.push_back(b[7:4]);
            host_q.push_back(b[3:0]);
            host_q.push_back(b[7:4]);
`ifdef ZB_FRAME_TX_FCS_EN
            crc = crc_step(crc_step(crc, b[3:0]), b[7:4]);
`endif
            nw += 2;
        end
`ifdef ZB_FRAME_TX_FCS_EN
        if (fcs >= 0) crc = 16'(fcs);
        exp_q.push_back(crc[3:0]);
        exp_q.push_back(crc[7:4]);
        exp_q.push_back(crc[11:8]);
        exp_q.push_back(crc[15:12]);
        nw += 4;
`else
        crc = 16'(fcs);
`endif
    endtask

    task automatic start(input logic [6:0] len);
        inStart  = 1'b1;
        inLength = len;
        tick(1);
        inStart  = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge inClock);
            #1;
            if (wr_cnt >= target) break;
        end
        if (i == budget) fail_now("wait_write_count");
        @(posedge inClock);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget, input int span);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge inClock);
            #1;
            if (outDone) break;
        end
        if (i == budget) begin
            fail_now({name, "_done_timeout"});
        end else begin
            check({name, "_busy_at_done"}, 32'(outBusy), 32'd1);
            check({name, "_all_written"}, 32'(exp_q.size()), 32'd0);
            check({name, "_write_span"}, 32'(last_wr - first_wr), 32'(span));
            @(negedge inClock);
            #1;
            check({name, "_busy_after"}, 32'(outBusy), 32'd0);
            check({name, "_done_pulse"}, 32'(outDone), 32'd0);
        end
        @(posedge inClock);
        #1;
    endtask

    task automatic reject(input string name, input logic [6:0] len);
        int w0, e0;
        w0 = wr_cnt;
        e0 = err_cnt;
        start(len);
        check({name, "_err_hi"}, 32'(outError), 32'd1);
        check({name, "_busy_lo"}, 32'(outBusy), 32'd0);
        tick(1);
        check({name, "_err_pulse"}, 32'(outError), 32'd0);
        tick(3);
        check({name, "_no_writes"}, 32'(wr_cnt), 32'(w0));
        check({name, "_err_count"}, 32'(err_cnt), 32'(e0 + 1));
        check({name, "_busy_idle"}, 32'(outBusy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, w0, w1, base;
        inReset  = 1'b0;
        inStart  = 1'b0;
        inLength = 7'd0;
        inFull   = 1'b0;
        #12;
        check("rst_we", 32'(outWriteEnable), 32'd0);
        check("rst_busy", 32'(outBusy), 32'd0);
        check("rst_ready", 32'(outReady), 32'd0);
        check("rst_done", 32'(outDone), 32'd0);
        check("rst_err", 32'(outError), 32'd0);
        check("rst_data", 32'(outData), 32'd0);
        @(negedge inClock);
        inReset = 1'b1;
        tick(2);

        // Basic one-byte frame.
        pay_q = '{8'h5A};
        push_frame(-1, nw);
        start(7'd1);
        wait_done("basic", 60, nw - 1);

        // FIFO full for 3 cycles after 4th preamble write.
        pay_q = '{8'h5A};
        push_frame(-1, nw);
        base = wr_cnt;
        start(7'd1);
        wait_wr(base + 4, 40);
        inFull = 1'b1;
        w0 = wr_cnt;
        tick(3);
        w1 = wr_cnt;
        inFull = 1'b0;
        check("bp_no_writes", 32'(w1), 32'(w0));
        wait_done("bp", 60, nw - 1 + 3);
        check("bp_total", 32'(wr_cnt - base), 32'(nw));

        // Host stall mid-payload plus ignored inStart.
        pay_q = '{8'h3C, 8'h96};
        push_frame(-1, nw);
        base = wr_cnt;
        start(7'd2);
        wait_wr(base + 13, 40);
        host_pause = 1'b1;
        w0 = wr_cnt;
        inStart  = 1'b1;
        inLength = 7'd5;
        tick(1);
        inStart  = 1'b0;
        tick(4);
        w1 = wr_cnt;
        host_pause = 1'b0;
        check("stall_no_writes", 32'(w1), 32'(w0));
        wait_done("stall", 80, nw - 1 + 5);
        tick(6);
        check("ignored_start_writes", 32'(wr_cnt - base), 32'(nw));
        check("ignored_start_busy", 32'(outBusy), 32'd0);

        // Length errors and the upper-length boundary.
        reject("len0", 7'd0);
`ifdef ZB_FRAME_TX_FCS_EN
        reject("len127", 7'd127);
`else
        pay_q.delete();
        for (int i = 0; i < 127; i++) pay_q.push_back(8'(i * 3 + 1));
        w0 = err_cnt;
        push_frame(-1, nw);
        start(7'd127);
        wait_done("max_len", 400, nw - 1);
        check("max_len_no_err", 32'(err_cnt), 32'(w0));
`endif

        // ASCII "123456789"; FCS build expects CRC 0x2189.
        pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_frame(16'h2189, nw);
        start(7'd9);
        wait_done("ascii", 80, nw - 1);

        // Reset in the middle of the payload.
        pay_q = '{8'h11, 8'h22, 8'h33};
        push_frame(-1, nw);
        base = wr_cnt;
        start(7'd3);
        wait_wr(base + 14, 40);
        #2;
        inReset = 1'b0;
        #1;
        check("mid_rst_we", 32'(outWriteEnable), 32'd0);
        check("mid_rst_busy", 32'(outBusy), 32'd0);
        check("mid_rst_ready", 32'(outReady), 32'd0);
        check("mid_rst_data", 32'(outData), 32'd0);
        check("mid_rst_done", 32'(outDone), 32'd0);
        exp_q.delete();
        host_q.delete();
        w0 = wr_cnt;
        tick(3);
        check("mid_rst_no_writes", 32'(wr_cnt), 32'(w0));
        inReset = 1'b1;
        tick(2);
        pay_q = '{8'h5A};
        push_frame(-1, nw);
        start(7'd1);
        wait_done("post_rst", 60, nw - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
